// File: rtl/icache_pkg.sv
// ----------------------------------------------------------------------------
// icache_pkg
//   Shared definitions for the two-way instruction cache: refill FSM state
//   encoding, fetch word geometry and the block word-select helper.
//   Contents:
//     DSIZE       fetch word width (32)
//     WORD_BYTES  bytes per fetch word
//     MAX_BSIZE   widest block (bits) that word_sel can handle
//     state_e     refill controller states {IDLE, MISS, FILL, DRAIN}
//     word_sel    picks word (offset / WORD_BYTES) from a block, word 0 in the MSBs
// ----------------------------------------------------------------------------
package icache_pkg;

    localparam int DSIZE      = 32;
    localparam int WORD_BYTES = DSIZE / 8;
    localparam int MAX_BSIZE  = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        FILL  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // block holds a bsize-bit block right-aligned; word k lives at
    // block[bsize-1-DSIZE*k -: DSIZE], so shift it down to bit 0.
    function automatic logic [DSIZE-1:0] word_sel(input logic [MAX_BSIZE-1:0] block,
                                                  input int bsize,
                                                  input int offset);
        int k;
        k = offset / WORD_BYTES;
        return DSIZE'(block >> (bsize - DSIZE * (k + 1)));
    endfunction

endpackage

// File: rtl/icache_way.sv
// ----------------------------------------------------------------------------
// icache_way
//   One way of the instruction cache: valid bits, tag array and block array,
//   plus tag compare and word select for the addressed set.
//   Ports:
//     CLK       clock, rising edge
//     RESET     synchronous active-low reset (clears valid bits)
//     flush     synchronous invalidate of every line
//     index     set being looked up or written
//     tag       lookup tag
//     offset    byte offset within the block (word = offset / 4)
//     wr_en     install wr_tag / wr_block at index and mark it valid
//     wr_tag    tag to install
//     wr_block  block to install
//     valid     valid bit of the addressed set (used for victim choice)
//     hit       valid and tag match at index
//     data      selected word of the addressed block
// ----------------------------------------------------------------------------
module icache_way
    import icache_pkg::*;
#(
    parameter int ASIZE = 32,
    parameter int BBITS = 5,
    parameter int IBITS = 7,
    localparam int TBITS = ASIZE - IBITS - BBITS,
    localparam int BSIZE = 8 << BBITS,
    localparam int SETS  = 1 << IBITS
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             flush,
    input  logic [IBITS-1:0] index,
    input  logic [TBITS-1:0] tag,
    input  logic [BBITS-1:0] offset,
    input  logic             wr_en,
    input  logic [TBITS-1:0] wr_tag,
    input  logic [BSIZE-1:0] wr_block,
    output logic             valid,
    output logic             hit,
    output logic [DSIZE-1:0] data
);

    logic [SETS-1:0]  valid_q, valid_d;
    logic [TBITS-1:0] tag_mem   [SETS];
    logic [BSIZE-1:0] block_mem [SETS];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[index] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: tag and block arrays are not reset; the valid bits alone decide whether their contents count.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_mem[index]   <= wr_tag;
            block_mem[index] <= wr_block;
        end
    end

    assign valid = valid_q[index];
    assign hit   = valid && (tag_mem[index] == tag);
    assign data  = word_sel(MAX_BSIZE'(block_mem[index]), BSIZE, int'(offset));

endmodule

// File: rtl/instr_cache_2way.sv
// ----------------------------------------------------------------------------
// instr_cache_2way
//   Two-way set-associative instruction cache with an integrated block
//   refill controller (IDLE -> MISS -> FILL -> IDLE, DRAIN after a flush
//   that lands mid-refill). Hits are combinational and served in IDLE only.
//   Build option: define ICACHE_STATS_EN to add saturating hit/miss counters.
//   Ports:
//     CLK, RESET            clock; synchronous active-low reset
//     SYS                   synchronous flush of all lines, aborts a refill
//     fetch_req/fetch_addr  fetch request and byte address
//     fetch_data/fetch_hit  selected word and hit flag
//     stall                 fetch must wait (miss or refill in progress)
//     mem_req/mem_addr      registered refill request, block-aligned address
//     mem_ack/mem_block     one-cycle refill acknowledge with block data
//     hit_count/miss_count  [ICACHE_STATS_EN] saturating event counters
// ----------------------------------------------------------------------------
module instr_cache_2way
    import icache_pkg::*;
#(
    parameter int ASIZE = 32,
    parameter int BBITS = 5,
    parameter int IBITS = 7,
    localparam int TBITS = ASIZE - IBITS - BBITS,
    localparam int BSIZE = 8 << BBITS,
    localparam int SETS  = 1 << IBITS
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             SYS,
    input  logic             fetch_req,
    input  logic [ASIZE-1:0] fetch_addr,
    output logic [DSIZE-1:0] fetch_data,
    output logic             fetch_hit,
    output logic             stall,
    output logic             mem_req,
    output logic [ASIZE-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [BSIZE-1:0] mem_block
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
`endif
);

    state_e                   state_q, state_d;
    logic [ASIZE-BBITS-1:0]   miss_blk_q, miss_blk_d;   // block address of the pending miss
    logic                     mem_req_q, mem_req_d;
    logic [BSIZE-1:0]         fill_block_q, fill_block_d;
    logic [SETS-1:0]          lru_q, lru_d;             // 1 = way 1 is least recently used

    logic [BBITS-1:0] f_offset;
    logic [IBITS-1:0] f_index, m_index, way_index;
    logic [TBITS-1:0] f_tag, m_tag;
    logic             hit0, hit1, v0, v1, any_hit, victim, wr0, wr1;
    logic [DSIZE-1:0] data0, data1;

    assign f_offset = fetch_addr[BBITS-1:0];
    assign f_index  = fetch_addr[IBITS+BBITS-1:BBITS];
    assign f_tag    = fetch_addr[ASIZE-1:IBITS+BBITS];
    assign m_index  = miss_blk_q[IBITS-1:0];
    assign m_tag    = miss_blk_q[ASIZE-BBITS-1:IBITS];

    // During FILL the ways are addressed by the latched miss, not the live fetch.
    assign way_index = (state_q == FILL) ? m_index : f_index;

    icache_way #(.ASIZE(ASIZE), .BBITS(BBITS), .IBITS(IBITS)) u_way0 (
        .CLK(CLK), .RESET(RESET), .flush(SYS), .index(way_index), .tag(f_tag),
        .offset(f_offset), .wr_en(wr0), .wr_tag(m_tag), .wr_block(fill_block_q),
        .valid(v0), .hit(hit0), .data(data0)
    );

    icache_way #(.ASIZE(ASIZE), .BBITS(BBITS), .IBITS(IBITS)) u_way1 (
        .CLK(CLK), .RESET(RESET), .flush(SYS), .index(way_index), .tag(f_tag),
        .offset(f_offset), .wr_en(wr1), .wr_tag(m_tag), .wr_block(fill_block_q),
        .valid(v1), .hit(hit1), .data(data1)
    );

    assign any_hit    = hit0 || hit1;
    assign fetch_hit  = fetch_req && (state_q == IDLE) && any_hit;
    assign fetch_data = hit0 ? data0 : data1;   // way 0 wins a (never legal) double match
    assign stall      = (state_q != IDLE) || (fetch_req && !any_hit);
    assign mem_req    = mem_req_q;
    assign mem_addr   = {miss_blk_q, {BBITS{1'b0}}};

    always_comb begin
        state_d      = state_q;
        miss_blk_d   = miss_blk_q;
        mem_req_d    = mem_req_q;
        fill_block_d = fill_block_q;
        lru_d        = lru_q;
        wr0          = 1'b0;
        wr1          = 1'b0;
        victim       = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru_q[m_index]);

        case (state_q)
            IDLE: begin
                if (SYS) begin
                    lru_d = '0;
                end else if (fetch_req && !any_hit) begin
                    miss_blk_d = fetch_addr[ASIZE-1:BBITS];
                    mem_req_d  = 1'b1;
                    state_d    = MISS;
                end else if (fetch_hit) begin
                    lru_d[f_index] = hit0;      // hit way becomes MRU, the other way LRU
                end
            end
            MISS: begin
                if (mem_ack) begin
                    fill_block_d = mem_block;
                    mem_req_d    = 1'b0;
                    // A flush coinciding with the ack completes the handshake and drops the block.
                    state_d      = SYS ? IDLE : FILL;
                end else if (SYS) begin
                    state_d = DRAIN;
                end
            end
            FILL: begin
                state_d = IDLE;
                if (SYS) begin
                    lru_d = '0;
                end else begin
                    wr0            = !victim;
                    wr1            = victim;
                    lru_d[m_index] = !victim;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= IDLE;
            miss_blk_q <= '0;
            mem_req_q  <= 1'b0;
            lru_q      <= '0;
        end else begin
            state_q    <= state_d;
            miss_blk_q <= miss_blk_d;
            mem_req_q  <= mem_req_d;
            lru_q      <= lru_d;
        end
    end

    always_ff @(posedge CLK) begin
        fill_block_q <= fill_block_d;
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (fetch_hit && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if ((state_q == IDLE) && (state_d == MISS) && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
